// File: rtl/flow_control_fsm.sv
// flow_control_fsm
// Link-level sequencing and flow control for the VC0/VC1 -> D0/D1 routing
// arbiter. Owns the RESET/INIT/IDLE/ACTIVE/ERROR state machine, latches the
// FIFO watermarks while in INIT, drives the D0/D1 pause lines with
// hysteresis and traps any FIFO overflow in a sticky ERROR state.
module flow_control_fsm #(
    parameter int FIFO_DEPTH   = 8,
    parameter int CW           = 4,
    parameter int UMB_ALTO_DEF = 6,
    parameter int UMB_BAJO_DEF = 2
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          init,
    input  logic [CW-1:0] umbral_alto_in,
    input  logic [CW-1:0] umbral_bajo_in,
    input  logic [CW-1:0] VC0_count,
    input  logic [CW-1:0] VC1_count,
    input  logic [CW-1:0] D0_count,
    input  logic [CW-1:0] D1_count,
    output logic          D0_pause,
    output logic          D1_pause,
    output logic [CW-1:0] umbral_alto,
    output logic [CW-1:0] umbral_bajo,
    output logic [2:0]    estado,
    output logic          idle_out,
    output logic          active_out,
    output logic          error_out
);

    localparam logic [2:0] ST_RESET  = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_IDLE   = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;

    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ALTO_DEF_C = CW'(UMB_ALTO_DEF);
    localparam logic [CW-1:0] BAJO_DEF_C = CW'(UMB_BAJO_DEF);
    localparam logic [CW-1:0] ZERO_C     = CW'(0);

    // Hysteresis: set at/above the high mark, clear at/below the low mark,
    // otherwise keep the previous pause value.
    function automatic logic f_hyst(
        input logic [CW-1:0] cnt,
        input logic [CW-1:0] alto,
        input logic [CW-1:0] bajo,
        input logic          prev
    );
        logic res;
        if (cnt >= alto) begin
            res = 1'b1;
        end else if (cnt <= bajo) begin
            res = 1'b0;
        end else begin
            res = prev;
        end
        return res;
    endfunction

    logic [2:0]    r_estado;
    logic [2:0]    w_estado_next;
    logic          r_d0_pause;
    logic          r_d1_pause;
    logic [CW-1:0] r_umbral_alto;
    logic [CW-1:0] r_umbral_bajo;
    logic          w_d0_pause_next;
    logic          w_d1_pause_next;
    logic [CW-1:0] w_alto_next;
    logic [CW-1:0] w_bajo_next;
    logic          w_ovf;
    logic          w_all_empty;
    logic          w_thr_valid;

    assign w_ovf = (VC0_count > DEPTH_C) || (VC1_count > DEPTH_C) ||
                   (D0_count  > DEPTH_C) || (D1_count  > DEPTH_C);

    assign w_all_empty = (VC0_count == ZERO_C) && (VC1_count == ZERO_C) &&
                         (D0_count  == ZERO_C) && (D1_count  == ZERO_C);

    assign w_thr_valid = (umbral_bajo_in < umbral_alto_in) &&
                         (umbral_alto_in <= DEPTH_C);

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_estado <= ST_RESET;
        end else begin
            r_estado <= w_estado_next;
        end
    end

    // Next-state logic; overflow outranks every other request outside RESET.
    always_comb begin
        w_estado_next = r_estado;
        case (r_estado)
            ST_RESET: begin
                w_estado_next = ST_INIT;
            end
            ST_INIT: begin
                if (w_ovf) begin
                    w_estado_next = ST_ERROR;
                end else if (init) begin
                    w_estado_next = ST_INIT;
                end else begin
                    w_estado_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_ovf) begin
                    w_estado_next = ST_ERROR;
                end else if (init) begin
                    w_estado_next = ST_INIT;
                end else if (!w_all_empty) begin
                    w_estado_next = ST_ACTIVE;
                end else begin
                    w_estado_next = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (w_ovf) begin
                    w_estado_next = ST_ERROR;
                end else if (w_all_empty) begin
                    w_estado_next = ST_IDLE;
                end else begin
                    w_estado_next = ST_ACTIVE;
                end
            end
            ST_ERROR: begin
                w_estado_next = ST_ERROR;
            end
            default: begin
                // Unused encodings are treated as a fault.
                w_estado_next = ST_ERROR;
            end
        endcase
    end

    // Output next-values: pause policy per state and threshold load in INIT.
    always_comb begin
        w_d0_pause_next = 1'b0;
        w_d1_pause_next = 1'b0;
        w_alto_next     = r_umbral_alto;
        w_bajo_next     = r_umbral_bajo;
        case (r_estado)
            ST_RESET: begin
                w_d0_pause_next = 1'b0;
                w_d1_pause_next = 1'b0;
            end
            ST_INIT, ST_ERROR: begin
                w_d0_pause_next = 1'b1;
                w_d1_pause_next = 1'b1;
            end
            ST_IDLE, ST_ACTIVE: begin
                w_d0_pause_next = f_hyst(D0_count, r_umbral_alto, r_umbral_bajo, r_d0_pause);
                w_d1_pause_next = f_hyst(D1_count, r_umbral_alto, r_umbral_bajo, r_d1_pause);
            end
            default: begin
                w_d0_pause_next = 1'b1;
                w_d1_pause_next = 1'b1;
            end
        endcase
        if ((r_estado == ST_INIT) && w_thr_valid) begin
            w_alto_next = umbral_alto_in;
            w_bajo_next = umbral_bajo_in;
        end else begin
            w_alto_next = r_umbral_alto;
            w_bajo_next = r_umbral_bajo;
        end
    end

    // Registered pause and watermark outputs.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_d0_pause    <= 1'b0;
            r_d1_pause    <= 1'b0;
            r_umbral_alto <= ALTO_DEF_C;
            r_umbral_bajo <= BAJO_DEF_C;
        end else begin
            r_d0_pause    <= w_d0_pause_next;
            r_d1_pause    <= w_d1_pause_next;
            r_umbral_alto <= w_alto_next;
            r_umbral_bajo <= w_bajo_next;
        end
    end

    assign D0_pause    = r_d0_pause;
    assign D1_pause    = r_d1_pause;
    assign umbral_alto = r_umbral_alto;
    assign umbral_bajo = r_umbral_bajo;
    assign estado      = r_estado;
    assign idle_out    = (r_estado == ST_IDLE);
    assign active_out  = (r_estado == ST_ACTIVE);
    assign error_out   = (r_estado == ST_ERROR);

endmodule

// File: tb/tb_flow_control_fsm.sv
// Directed self-checking bench for flow_control_fsm. Each step drives the
// inputs, pushes the expected post-edge outputs to a scoreboard queue, then
// pops and compares them one time unit after the clock edge.
module tb_flow_control_fsm;

    localparam int CW = 4;

    logic          clk;
    logic          reset_L;
    logic          init;
    logic [CW-1:0] umbral_alto_in;
    logic [CW-1:0] umbral_bajo_in;
    logic [CW-1:0] VC0_count;
    logic [CW-1:0] VC1_count;
    logic [CW-1:0] D0_count;
    logic [CW-1:0] D1_count;
    logic          D0_pause;
    logic          D1_pause;
    logic [CW-1:0] umbral_alto;
    logic [CW-1:0] umbral_bajo;
    logic [2:0]    estado;
    logic          idle_out;
    logic          active_out;
    logic          error_out;

    typedef struct packed {
        logic [2:0]    st;
        logic          p0;
        logic          p1;
        logic [CW-1:0] hi;
        logic [CW-1:0] lo;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    flow_control_fsm #(
        .FIFO_DEPTH  (8),
        .CW          (CW),
        .UMB_ALTO_DEF(6),
        .UMB_BAJO_DEF(2)
    ) dut (
        .clk           (clk),
        .reset_L       (reset_L),
        .init          (init),
        .umbral_alto_in(umbral_alto_in),
        .umbral_bajo_in(umbral_bajo_in),
        .VC0_count     (VC0_count),
        .VC1_count     (VC1_count),
        .D0_count      (D0_count),
        .D1_count      (D1_count),
        .D0_pause      (D0_pause),
        .D1_pause      (D1_pause),
        .umbral_alto   (umbral_alto),
        .umbral_bajo   (umbral_bajo),
        .estado        (estado),
        .idle_out      (idle_out),
        .active_out    (active_out),
        .error_out     (error_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int step, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s step %0d: observed %0h expected %0h", tag, step, obs, expv);
        end
    endtask

    // Push expectation, clock once, then pop and compare all outputs.
    task automatic cyc(input int step, input logic [2:0] st, input logic p0, input logic p1,
                       input logic [CW-1:0] hi, input logic [CW-1:0] lo);
        exp_t e;
        e.st = st; e.p0 = p0; e.p1 = p1; e.hi = hi; e.lo = lo;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard step %0d: observed empty queue expected entry", step);
        end else begin
            e = sb_q.pop_front();
            chk("estado",      step, {5'd0, estado},      {5'd0, e.st});
            chk("D0_pause",    step, {7'd0, D0_pause},    {7'd0, e.p0});
            chk("D1_pause",    step, {7'd0, D1_pause},    {7'd0, e.p1});
            chk("umbral_alto", step, {4'd0, umbral_alto}, {4'd0, e.hi});
            chk("umbral_bajo", step, {4'd0, umbral_bajo}, {4'd0, e.lo});
            chk("idle_out",    step, {7'd0, idle_out},    {7'd0, (e.st == 3'd2)});
            chk("active_out",  step, {7'd0, active_out},  {7'd0, (e.st == 3'd3)});
            chk("error_out",   step, {7'd0, error_out},   {7'd0, (e.st == 3'd4)});
        end
    endtask

    initial begin
        reset_L = 1'b0; init = 1'b0;
        umbral_alto_in = 4'd0; umbral_bajo_in = 4'd0;
        VC0_count = 4'd0; VC1_count = 4'd0; D0_count = 4'd0; D1_count = 4'd0;

        // Reset and power-up walk RESET -> INIT -> IDLE.
        cyc(1, 3'd0, 1'b0, 1'b0, 4'd6, 4'd2);
        reset_L = 1'b1;
        cyc(2, 3'd1, 1'b0, 1'b0, 4'd6, 4'd2);
        cyc(3, 3'd2, 1'b1, 1'b1, 4'd6, 4'd2);  // forced pause from INIT
        cyc(4, 3'd2, 1'b0, 1'b0, 4'd6, 4'd2);

        // Reconfigure: valid 5/1, then invalid 3/4 dropped with init.
        init = 1'b1; umbral_alto_in = 4'd5; umbral_bajo_in = 4'd1;
        cyc(5, 3'd1, 1'b0, 1'b0, 4'd6, 4'd2);
        cyc(6, 3'd1, 1'b1, 1'b1, 4'd5, 4'd1);
        umbral_alto_in = 4'd3; umbral_bajo_in = 4'd4;
        cyc(7, 3'd1, 1'b1, 1'b1, 4'd5, 4'd1);
        init = 1'b0;
        cyc(8, 3'd2, 1'b1, 1'b1, 4'd5, 4'd1);
        cyc(9, 3'd2, 1'b0, 1'b0, 4'd5, 4'd1);

        // Boundary thresholds: alto 9 rejected, alto 8 accepted, then 6/2.
        init = 1'b1;
        cyc(10, 3'd1, 1'b0, 1'b0, 4'd5, 4'd1);
        umbral_alto_in = 4'd9; umbral_bajo_in = 4'd2;
        cyc(11, 3'd1, 1'b1, 1'b1, 4'd5, 4'd1);
        umbral_alto_in = 4'd8; umbral_bajo_in = 4'd7;
        cyc(12, 3'd1, 1'b1, 1'b1, 4'd8, 4'd7);
        umbral_alto_in = 4'd6; umbral_bajo_in = 4'd2;
        cyc(13, 3'd1, 1'b1, 1'b1, 4'd6, 4'd2);
        init = 1'b0;
        cyc(14, 3'd2, 1'b1, 1'b1, 4'd6, 4'd2);
        cyc(15, 3'd2, 1'b0, 1'b0, 4'd6, 4'd2);

        // IDLE <-> ACTIVE on traffic; init ignored while ACTIVE.
        VC0_count = 4'd1;
        cyc(16, 3'd3, 1'b0, 1'b0, 4'd6, 4'd2);
        VC0_count = 4'd0;
        cyc(17, 3'd2, 1'b0, 1'b0, 4'd6, 4'd2);
        VC0_count = 4'd1;
        cyc(18, 3'd3, 1'b0, 1'b0, 4'd6, 4'd2);
        init = 1'b1; umbral_alto_in = 4'd4; umbral_bajo_in = 4'd1;
        cyc(19, 3'd3, 1'b0, 1'b0, 4'd6, 4'd2);
        cyc(20, 3'd3, 1'b0, 1'b0, 4'd6, 4'd2);
        init = 1'b0; umbral_alto_in = 4'd0; umbral_bajo_in = 4'd0;

        // Hysteresis sweep on D0; count == depth is legal.
        D0_count = 4'd3; cyc(21, 3'd3, 1'b0, 1'b0, 4'd6, 4'd2);
        D0_count = 4'd6; cyc(22, 3'd3, 1'b1, 1'b0, 4'd6, 4'd2);
        D0_count = 4'd5; cyc(23, 3'd3, 1'b1, 1'b0, 4'd6, 4'd2);
        D0_count = 4'd3; cyc(24, 3'd3, 1'b1, 1'b0, 4'd6, 4'd2);
        D0_count = 4'd2; cyc(25, 3'd3, 1'b0, 1'b0, 4'd6, 4'd2);
        D0_count = 4'd8; cyc(26, 3'd3, 1'b1, 1'b0, 4'd6, 4'd2);
        D0_count = 4'd2; cyc(27, 3'd3, 1'b0, 1'b0, 4'd6, 4'd2);

        // Overflow on D1 -> sticky ERROR; only reset leaves it.
        D1_count = 4'd9;
        cyc(28, 3'd4, 1'b0, 1'b1, 4'd6, 4'd2);
        D1_count = 4'd0; D0_count = 4'd0; VC0_count = 4'd0;
        cyc(29, 3'd4, 1'b1, 1'b1, 4'd6, 4'd2);
        init = 1'b1;
        cyc(30, 3'd4, 1'b1, 1'b1, 4'd6, 4'd2);
        init = 1'b0; reset_L = 1'b0;
        cyc(31, 3'd0, 1'b0, 1'b0, 4'd6, 4'd2);

        // Back to IDLE, then init and overflow together: ERROR wins.
        reset_L = 1'b1;
        cyc(32, 3'd1, 1'b0, 1'b0, 4'd6, 4'd2);
        cyc(33, 3'd2, 1'b1, 1'b1, 4'd6, 4'd2);
        cyc(34, 3'd2, 1'b0, 1'b0, 4'd6, 4'd2);
        init = 1'b1; D0_count = 4'd9;
        cyc(35, 3'd4, 1'b1, 1'b0, 4'd6, 4'd2);

        // Overflow ignored in RESET, caught in INIT.
        init = 1'b0; reset_L = 1'b0;
        cyc(36, 3'd0, 1'b0, 1'b0, 4'd6, 4'd2);
        reset_L = 1'b1;
        cyc(37, 3'd1, 1'b0, 1'b0, 4'd6, 4'd2);
        cyc(38, 3'd4, 1'b1, 1'b1, 4'd6, 4'd2);
        D0_count = 4'd0; reset_L = 1'b0;
        cyc(39, 3'd0, 1'b0, 1'b0, 4'd6, 4'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
